// File: rtl/vga_cfg_arbiter.sv
// Round-robin arbiter sequencing VGA resolution changes: validate, one-cycle write, wait for load (timeout), ack, hold-off.
// Ack lands 3 cycles after grant (1 if rejected); VGA_CFG_SKIP_SAME_EN skips the bus when the mode is already applied.
module vga_cfg_arbiter #(
  parameter int                      CONFIG_WIDTH    = 8,
  parameter logic [CONFIG_WIDTH-1:0] ADDR_VGA_CONFIG = {{(CONFIG_WIDTH-1){1'b0}}, 1'b1},
  parameter int                      TIMEOUT         = 16,
  parameter int                      GAP_CYCLES      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic [CONFIG_WIDTH-1:0] addr0,
  input  logic [CONFIG_WIDTH-1:0] data0,
  output logic                    ack0,
  output logic                    err0,
  input  logic                    req1,
  input  logic [CONFIG_WIDTH-1:0] addr1,
  input  logic [CONFIG_WIDTH-1:0] data1,
  output logic                    ack1,
  output logic                    err1,
  output logic                    c_valid,
  output logic [CONFIG_WIDTH-1:0] c_addr,
  output logic [CONFIG_WIDTH-1:0] c_data,
  input  logic                    c_ready,
  output logic                    busy,
  output logic [1:0]              cur_mode
);

  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CONFIG_WIDTH-1:0] MAX_CODE = CONFIG_WIDTH'(2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RDY, RESP, HOLDOFF} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    rr, rr_nx;
  logic                    gnt, gnt_nx;
  logic                    bus_q, bus_nx;
  logic [1:0]              pend_mode, pend_nx;
  logic [1:0]              mode_nx;
  logic                    err_nx;
  logic                    ack0_nx, ack1_nx, err0_nx, err1_nx;
  logic                    c_valid_nx, busy_nx;
  logic [CONFIG_WIDTH-1:0] c_addr_nx, c_data_nx;

  logic                    any_req, sel, sel_ok;
  logic [CONFIG_WIDTH-1:0] sel_addr, sel_data;

  // rr holds the last granted requester; on a tie the other one wins.
  always_comb begin
    any_req  = req0 | req1;
    sel      = (req0 && req1) ? ~rr : req1;
    sel_addr = sel ? addr1 : addr0;
    sel_data = sel ? data1 : data0;
    sel_ok   = (sel_addr == ADDR_VGA_CONFIG) && (sel_data <= MAX_CODE);
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rr_nx     = rr;
    gnt_nx    = gnt;
    bus_nx    = bus_q;
    pend_nx   = pend_mode;
    mode_nx   = cur_mode;
    err_nx    = 1'b0;
    c_addr_nx = '0;
    c_data_nx = '0;

    case (state)
      IDLE: begin
        if (any_req) begin
          rr_nx  = sel;
          gnt_nx = sel;
          if (!sel_ok) begin
            state_nx = RESP;
            err_nx   = 1'b1;
            bus_nx   = 1'b0;
          end
`ifdef VGA_CFG_SKIP_SAME_EN
          else if (sel_data[1:0] == cur_mode) begin
            state_nx = RESP;
            bus_nx   = 1'b0;
          end
`endif
          else begin
            state_nx  = ISSUE;
            bus_nx    = 1'b1;
            pend_nx   = sel_data[1:0];
            c_addr_nx = sel_addr;
            c_data_nx = sel_data;
          end
        end
      end

      ISSUE: begin
        state_nx = WAIT_RDY;
        cnt_nx   = '0;
      end

      // A load pulse on the final timeout cycle still counts as success.
      WAIT_RDY: begin
        if (c_ready) begin
          state_nx = RESP;
          mode_nx  = pend_mode;
        end else if (cnt == TO_LAST) begin
          state_nx = RESP;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      RESP: begin
        if (bus_q && (GAP_CYCLES > 0)) begin
          state_nx = HOLDOFF;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end

      HOLDOFF: begin
        if (cnt == GAP_LAST) state_nx = IDLE;
        else                 cnt_nx   = cnt + 1'b1;
      end

      default: state_nx = IDLE;
    endcase

    c_valid_nx = (state_nx == ISSUE);
    busy_nx    = (state_nx != IDLE);
    ack0_nx    = (state_nx == RESP) && !gnt_nx;
    ack1_nx    = (state_nx == RESP) &&  gnt_nx;
    err0_nx    = ack0_nx && err_nx;
    err1_nx    = ack1_nx && err_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr        <= 1'b1;
      gnt       <= 1'b0;
      bus_q     <= 1'b0;
      pend_mode <= 2'b00;
      cur_mode  <= 2'b00;
      ack0      <= 1'b0;
      err0      <= 1'b0;
      ack1      <= 1'b0;
      err1      <= 1'b0;
      c_valid   <= 1'b0;
      c_addr    <= '0;
      c_data    <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rr        <= rr_nx;
      gnt       <= gnt_nx;
      bus_q     <= bus_nx;
      pend_mode <= pend_nx;
      cur_mode  <= mode_nx;
      ack0      <= ack0_nx;
      err0      <= err0_nx;
      ack1      <= ack1_nx;
      err1      <= err1_nx;
      c_valid   <= c_valid_nx;
      c_addr    <= c_addr_nx;
      c_data    <= c_data_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_vga_cfg_arbiter.sv
// Bench for vga_cfg_arbiter: vector table plus hand sequences, acks scored against a queue of expected results.
module tb_vga_cfg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] addr0, data0, addr1, data1;
  logic       ack0, err0, ack1, err1;
  logic       c_valid;
  logic [7:0] c_addr, c_data;
  logic       c_ready, c_ready_auto, c_ready_man;
  logic       busy;
  logic [1:0] cur_mode;

  assign c_ready = c_ready_auto | c_ready_man;

  vga_cfg_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1), .err1(err1),
    .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
    .busy(busy), .cur_mode(cur_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [7:0] addr;
    logic [7:0] data;
    int         rdy;   // WAIT_RDY cycle that sees c_ready; 0 = never
    bit         err;
    logic [1:0] mode;
    int         lat;   // posedges from grant edge (counted as 1) to ack
    int         cv;
    int         gap;
  } vec_t;

  typedef struct {
    int         who;
    bit         err;
    logic [1:0] mode;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         rdy_cycle = 0;
  int         wcnt = 0;
  logic [1:0] mode_exp = 2'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Load-pulse model: asserts c_ready on the chosen WAIT_RDY cycle after c_valid.
  always @(negedge clk) begin
    c_ready_auto = 1'b0;
    if (c_valid) wcnt = 1;
    else if (wcnt > 0) begin
      if (wcnt == rdy_cycle) c_ready_auto = 1'b1;
      wcnt = (wcnt > 100) ? 0 : wcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (ack0 || ack1) begin
      if (sb.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_who", ack1 ? 1 : 0, e.who);
        chk("ack_err", ack1 ? int'(err1) : int'(err0), int'(e.err));
        chk("cur_mode_at_ack", cur_mode, e.mode);
      end
    end
    if (!ack0 && err0) chk("err0_without_ack", err0, 0);
    if (!ack1 && err1) chk("err1_without_ack", err1, 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mode_exp = 2'd0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic apply(input vec_t v);
    int lat, cv, gap, ex_lat, ex_cv, ex_gap;
    bit got, ex_err;
    exp_t e;
    ex_lat = v.lat; ex_cv = v.cv; ex_gap = v.gap; ex_err = v.err;
`ifdef VGA_CFG_SKIP_SAME_EN
    if (v.addr == 8'h01 && v.data <= 8'h02 && v.data[1:0] == mode_exp) begin
      ex_lat = 1; ex_cv = 0; ex_gap = 0; ex_err = 1'b0;
    end
`endif
    e.who = v.who; e.err = ex_err; e.mode = v.mode;
    sb.push_back(e);
    mode_exp = v.mode;
    rdy_cycle = v.rdy;
    if (v.who == 0) begin req0 = 1'b1; addr0 = v.addr; data0 = v.data; end
    else            begin req1 = 1'b1; addr1 = v.addr; data1 = v.data; end
    lat = 0; cv = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (c_valid) begin
        cv++;
        chk("c_addr", c_addr, v.addr);
        chk("c_data", c_data, v.data);
      end
      if ((v.who == 0 && ack0) || (v.who == 1 && ack1)) got = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("ack_seen", got, 1);
    chk("ack_latency", lat, ex_lat);
    chk("c_valid_cycles", cv, ex_cv);
    gap = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
      gap++;
    end
    chk("holdoff_cycles", gap, ex_gap);
  endtask

  vec_t tbl[9];
  vec_t pv;
  int   got, cv, last;

  initial begin
    tbl[0] = '{0, 8'h01, 8'h01,  1, 1'b0, 2'd1,  3, 1, 4};
    tbl[1] = '{1, 8'h01, 8'h03,  1, 1'b1, 2'd1,  1, 0, 0};
    tbl[2] = '{1, 8'h02, 8'h01,  1, 1'b1, 2'd1,  1, 0, 0};
    tbl[3] = '{0, 8'h01, 8'h02,  0, 1'b1, 2'd1, 18, 1, 4};
    tbl[4] = '{0, 8'h01, 8'h02, 16, 1'b0, 2'd2, 18, 1, 4};
    tbl[5] = '{1, 8'h01, 8'h00,  3, 1'b0, 2'd0,  5, 1, 4};
    tbl[6] = '{1, 8'h01, 8'h00,  1, 1'b0, 2'd0,  3, 1, 4};
    tbl[7] = '{0, 8'h01, 8'h04,  1, 1'b1, 2'd0,  1, 0, 0};
    tbl[8] = '{0, 8'h01, 8'h02, 15, 1'b0, 2'd2, 17, 1, 4};

    addr0 = 8'h00; data0 = 8'h00; addr1 = 8'h00; data1 = 8'h00;
    c_ready_man = 1'b0;
    do_reset();

    chk("rst_busy", busy, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_addr", c_addr, 0);
    chk("rst_c_data", c_data, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_err", {err1, err0}, 0);
    chk("rst_cur_mode", cur_mode, 0);

    for (int i = 0; i < 9; i++) apply(tbl[i]);

    // Both requesters held continuously: grants must alternate starting with 0.
    do_reset();
    rdy_cycle = 1;
    req0 = 1'b1; addr0 = 8'h01; data0 = 8'h01;
    req1 = 1'b1; addr1 = 8'h01; data1 = 8'h02;
    for (int k = 0; k < 4; k++) sb.push_back('{k % 2, 1'b0, (k % 2 == 0) ? 2'd1 : 2'd2});
    last = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0; cv = 0;
      for (int t = 0; t < 40 && got == 0; t++) begin
        @(negedge clk);
        if (c_valid) cv++;
        if (ack0 || ack1) got = 1;
      end
      chk("rr_ack_seen", got, 1);
      chk("rr_bus_cycles", cv, 1);
      if (k > 0) chk("rr_ack_spacing", cyc - last, 8);
      last = cyc;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // Reset while waiting for the load pulse; a late pulse must be ignored.
    rdy_cycle = 0;
    req0 = 1'b1; addr0 = 8'h01; data0 = 8'h01;
    got = 0;
    for (int t = 0; t < 10 && got == 0; t++) begin
      @(negedge clk);
      if (c_valid) got = 1;
    end
    chk("abort_c_valid_seen", got, 1);
    @(negedge clk); @(negedge clk);
    chk("abort_busy_before", busy, 1);
    chk("abort_mode_before", cur_mode, 2);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mode_exp = 2'd0;
    chk("abort_busy", busy, 0);
    chk("abort_c_valid", c_valid, 0);
    chk("abort_ack0", ack0, 0);
    chk("abort_cur_mode", cur_mode, 0);
    c_ready_man = 1'b1;
    @(negedge clk);
    c_ready_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rdy_busy", busy, 0);
      chk("late_rdy_mode", cur_mode, 0);
    end

    // Same-mode request right after reset.
    pv = '{0, 8'h01, 8'h00, 1, 1'b0, 2'd0, 3, 1, 4};
    apply(pv);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_cfg_arbiter.md
Name: vga_cfg_arbiter

Overview:
- Shares the VGA configuration bus (c_valid/c_addr/c_data, c_ready) between two requesters, e.g. the CPU register port and the front-panel mode switch.
- Sequences each resolution change as one transaction:
  - validate the request;
  - issue a single-cycle write;
  - wait for the VGA load pulse, with a timeout;
  - return a per-requester ack with error status;
  - enforce a hold-off gap so the VGA counters settle before the next change.
- Sits between the requesters and the VGA top, which drives Load_config onto c_ready.

Parameters:
- CONFIG_WIDTH, 8: width of the address and data fields of the config bus.
- ADDR_VGA_CONFIG, 8'h01: the only address this block services.
- TIMEOUT, 16: number of WAIT_RDY cycles before the transaction is declared failed; must be ≥1.
- GAP_CYCLES, 4: number of hold-off cycles after every bus transaction; 0 means no hold-off.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- req0  in  1  requester 0 request level
- addr0  in  CONFIG_WIDTH  requester 0 address
- data0  in  CONFIG_WIDTH  requester 0 data (resolution code)
- ack0  out  1  requester 0 completion pulse
- err0  out  1  requester 0 error flag, valid with ack0
- req1, addr1, data1, ack1, err1: same as requester 0, for requester 1
- c_valid  out  1  config bus write strobe
- c_addr  out  CONFIG_WIDTH  config bus address
- c_data  out  CONFIG_WIDTH  config bus data
- c_ready  in  1  VGA load pulse
- busy  out  1  high in every state except IDLE
- cur_mode  out  2  last resolution code applied successfully

Behaviour:
- Reset (rst sampled high on a clk edge):
  - state = IDLE; all outputs 0 except cur_mode = 2'b00 (640x480 default);
  - rr pointer = 1, so requester 0 wins the first tie.
  - Reset mid-transaction aborts it: no ack is given and c_valid drops on the next edge.
- All outputs are registered.
- Requester rules:
  - hold req high with stable addr/data until ack;
  - ack is a one-cycle pulse; err is valid only while ack = 1;
  - a req seen in its own ack cycle is ignored.
- Arbitration in IDLE is round-robin: if both requesters are active, the one not granted last wins. rr updates on grant, including grants that are rejected.
- Validation at grant: the request is valid iff addr == ADDR_VGA_CONFIG and data ≤ 2.
- States:
  - IDLE:
    - no req → stay;
    - granted and invalid → RESP with err = 1; no bus cycle, no hold-off;
    - granted and valid → ISSUE; latch addr, data, grant.
  - ISSUE: c_valid = 1 for exactly one cycle, with c_addr/c_data latched. c_ready is ignored in this cycle. Next → WAIT_RDY with cnt = 0.
  - WAIT_RDY:
    - c_ready = 1 → RESP with err = 0; cur_mode ← data[1:0];
    - otherwise cnt++; when cnt == TIMEOUT-1 with no c_ready → RESP with err = 1; cur_mode unchanged.
    - c_ready on the timeout cycle counts as success.
  - RESP: ack of the granted requester = 1 and its err as above. Next:
    - → HOLDOFF if a bus cycle occurred and GAP_CYCLES > 0;
    - otherwise → IDLE.
  - HOLDOFF: count GAP_CYCLES cycles, then → IDLE. Requests are held pending, not dropped.
- Nominal latency, grant edge to ack: 1 (ISSUE) + 1 (WAIT_RDY, c_ready at the earliest) + 1 (RESP) = ack 3 cycles after the grant edge.
- A rejected request is acked 1 cycle after the grant edge.
- c_ready outside WAIT_RDY is ignored and has no effect.
- The VGA asserts Load_config after reset; the arbiter ignores it because it arrives in IDLE.
- The counter width is enough to hold max(TIMEOUT, GAP_CYCLES); no wrap is possible.

Optional Feature:
- Macro: VGA_CFG_SKIP_SAME_EN.
- Defined: a valid request with data[1:0] == cur_mode skips the bus entirely. Sequence is IDLE → RESP with err = 0; no c_valid, no hold-off, ack 1 cycle after grant.
- Undefined: every valid request performs the full bus transaction, even when the mode is unchanged.

Test Plan:
- Reset, then req0 with addr = 8'h01, data = 8'h01, c_ready returned 1 cycle after c_valid:
  - c_valid for 1 cycle with c_data = 8'h01;
  - ack0 = 1, err0 = 0 exactly 3 cycles after the grant;
  - cur_mode = 2'b01;
  - busy stays high for 4 further cycles of HOLDOFF.
- req0 and req1 both valid and continuously asserted: grants alternate 0, 1, 0, 1; no grant during HOLDOFF; neither requester is starved.
- req1 with data = 8'h03, or with addr = 8'h02:
  - ack1 = 1, err1 = 1 one cycle after grant;
  - c_valid never asserted; no HOLDOFF; cur_mode unchanged.
- req0 valid with c_ready held at 0:
  - ack0 = 1, err0 = 1 after 16 WAIT_RDY cycles;
  - cur_mode unchanged.
  - Rerun with c_ready on WAIT_RDY cycle 16 → err0 = 0.
- rst asserted during WAIT_RDY:
  - next cycle: IDLE, no ack, cur_mode = 0;
  - a late c_ready is ignored.
- With VGA_CFG_SKIP_SAME_EN defined: req0 data = 8'h00 straight after reset → ack0 = 1, err0 = 0 one cycle after grant, c_valid stays 0.
